cnn_layer_accel_input_loader: RTL and testbench

//  Upstream feeder for cnn_layer_accel_octo. Generates the per-map sequence-word

---
 rtl/cnn_layer_accel_input_loader.sv | 189 ++++++++++++++++++
 tb/tb_cnn_layer_accel_input_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_input_loader.sv
// Front-end feeder for cnn_layer_accel_octo: emits the generated sequence-word table on datain,
// then forwards the input map's raster pixel stream, one run per accepted start pulse.
module cnn_layer_accel_input_loader #(
    parameter int C_PIXEL_WIDTH    = 16,
    parameter int C_SEQ_DATA_WIDTH = 13,
    parameter int C_DIM_WIDTH      = 10,
    parameter int C_DATAIN_WIDTH   = (C_PIXEL_WIDTH > C_SEQ_DATA_WIDTH) ? C_PIXEL_WIDTH : C_SEQ_DATA_WIDTH
) (
    input  logic                        clk_500MHz,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [C_DIM_WIDTH-1:0]      cfg_rows,
    input  logic [C_DIM_WIDTH-1:0]      cfg_cols,
    input  logic [C_DIM_WIDTH-1:0]      cfg_kernel,
    input  logic [C_PIXEL_WIDTH-1:0]    pix_in_data,
    input  logic                        pix_in_valid,
    output logic                        pix_in_rdy,
    output logic [C_DATAIN_WIDTH-1:0]   datain,
    output logic                        datain_valid,
    output logic                        seq_datain_tag,
    input  logic                        seq_datain_rdy,
    output logic                        pixel_datain_tag,
    input  logic                        pixel_datain_rdy,
    output logic                        busy,
    output logic                        done,
    output logic                        cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_SEQ, S_PIX, S_DONE} state_t;

    localparam logic [C_DIM_WIDTH-1:0] DIM_ONE = 1;
    localparam logic [C_DIM_WIDTH:0]   GRP_ONE = 1;

    state_t                      state;
    logic [C_DIM_WIDTH-1:0]      rows_q;
    logic [C_DIM_WIDTH-1:0]      cols_q;
    logic [C_DIM_WIDTH:0]        groups_q;
    logic [C_DIM_WIDTH:0]        grp;
    logic [2:0]                  widx;
    logic [9:0]                  seq0, seq1, seq2, seq3, seq4;
    logic                        p_a, p_b, step;
    logic [C_DIM_WIDTH-1:0]      row, col;
    logic                        pix_all;

    logic                        seq_xfer, pix_xfer, pix_acc, seq_more, cfg_bad;
    logic [C_SEQ_DATA_WIDTH-1:0] seq_word;
    logic [C_DATAIN_WIDTH-1:0]   seq_ext, pix_ext;

    assign seq_xfer   = datain_valid & seq_datain_tag & seq_datain_rdy;
    assign pix_xfer   = datain_valid & pixel_datain_tag & pixel_datain_rdy;
    assign pix_in_rdy = (state == S_PIX) & ~pix_all & (~datain_valid | pixel_datain_rdy);
    assign pix_acc    = pix_in_valid & pix_in_rdy;
    assign seq_more   = (grp != groups_q);
    assign cfg_bad    = (cfg_kernel == '0) | (cfg_kernel > cfg_rows) | (cfg_kernel > cfg_cols);

    // Word {RM, RST, P, SEQ} for the current position within the group being emitted.
    always_comb begin
        seq_word = '0;
        case (widx)
            3'd0:    seq_word = {1'b0, 1'b1, p_a, seq0};
            3'd1:    seq_word = {1'b0, 1'b0, p_b, seq1};
            3'd2:    seq_word = {3'b000, seq2};
            3'd3:    seq_word = {3'b000, seq3};
            default: seq_word = {3'b100, seq4};
        endcase
        seq_ext = '0;
        seq_ext[C_SEQ_DATA_WIDTH-1:0] = seq_word;
        pix_ext = '0;
        pix_ext[C_PIXEL_WIDTH-1:0] = pix_in_data;
    end

    // The output register doubles as the one-deep skid slot for both word kinds.
    always_ff @(posedge clk_500MHz or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            datain           <= '0;
            datain_valid     <= 1'b0;
            seq_datain_tag   <= 1'b0;
            pixel_datain_tag <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            cfg_err          <= 1'b0;
            rows_q           <= '0;
            cols_q           <= '0;
            groups_q         <= '0;
            grp              <= '0;
            widx             <= '0;
            seq0             <= '0;
            seq1             <= '0;
            seq2             <= '0;
            seq3             <= '0;
            seq4             <= '0;
            p_a              <= 1'b0;
            p_b              <= 1'b0;
            step             <= 1'b0;
            row              <= '0;
            col              <= '0;
            pix_all          <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            cfg_err <= 1'b1;
                        end else begin
                            state    <= S_SEQ;
                            busy     <= 1'b1;
                            rows_q   <= cfg_rows;
                            cols_q   <= cfg_cols;
                            groups_q <= {1'b0, cfg_cols} - {1'b0, cfg_kernel} + GRP_ONE;
                            grp      <= '0;
                            widx     <= '0;
                            seq0     <= 10'd0;
                            seq1     <= 10'd2;
                            seq2     <= 10'd512;
                            seq3     <= 10'd513;
                            seq4     <= 10'd514;
                            p_a      <= 1'b1;
                            p_b      <= 1'b0;
                            step     <= 1'b0;
                            row      <= '0;
                            col      <= '0;
                            pix_all  <= 1'b0;
                        end
                    end
                end
                S_SEQ: begin
                    if ((!datain_valid || seq_xfer) && seq_more) begin
                        datain         <= seq_ext;
                        datain_valid   <= 1'b1;
                        seq_datain_tag <= 1'b1;
                        if (widx == 3'd4) begin
                            // Group complete: derive the next group's words from this one.
                            widx <= '0;
                            grp  <= grp + GRP_ONE;
                            seq0 <= seq0 + 10'd1;
                            seq1 <= seq1 + (step ? 10'd2 : 10'd0);
                            seq2 <= seq2 + 10'd1;
                            seq3 <= seq3 + 10'd1;
                            seq4 <= seq4 + 10'd1;
                            p_a  <= ~p_a;
                            p_b  <= ~p_b;
                            step <= ~step;
                        end else begin
                            widx <= widx + 3'd1;
                        end
                    end else if (seq_xfer) begin
                        datain_valid   <= 1'b0;
                        seq_datain_tag <= 1'b0;
                        state          <= S_PIX;
                    end
                end
                S_PIX: begin
                    if (pix_acc) begin
                        datain           <= pix_ext;
                        datain_valid     <= 1'b1;
                        pixel_datain_tag <= 1'b1;
                        if (col == cols_q - DIM_ONE) begin
                            col <= '0;
                            row <= row + DIM_ONE;
                            if (row == rows_q - DIM_ONE) begin
                                pix_all <= 1'b1;
                            end
                        end else begin
                            col <= col + DIM_ONE;
                        end
                    end else if (pix_xfer) begin
                        datain_valid     <= 1'b0;
                        pixel_datain_tag <= 1'b0;
                        if (pix_all) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_input_loader.sv
// Randomized self-checking bench for cnn_layer_accel_input_loader against a closed-form
// model of the sequence table and a queue of the pixels offered upstream.
module tb_cnn_layer_accel_input_loader;

    localparam int PW  = 16;
    localparam int SW  = 13;
    localparam int DIM = 10;
    localparam int DW  = 16;

    logic           clk_500MHz = 1'b0;
    logic           rst_n;
    logic           start;
    logic [DIM-1:0] cfg_rows, cfg_cols, cfg_kernel;
    logic [PW-1:0]  pix_in_data;
    logic           pix_in_valid;
    logic           pix_in_rdy;
    logic [DW-1:0]  datain;
    logic           datain_valid;
    logic           seq_datain_tag;
    logic           seq_datain_rdy;
    logic           pixel_datain_tag;
    logic           pixel_datain_rdy;
    logic           busy;
    logic           done;
    logic           cfg_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_500MHz = ~clk_500MHz;

    cnn_layer_accel_input_loader #(
        .C_PIXEL_WIDTH    (PW),
        .C_SEQ_DATA_WIDTH (SW),
        .C_DIM_WIDTH      (DIM),
        .C_DATAIN_WIDTH   (DW)
    ) dut (
        .clk_500MHz       (clk_500MHz),
        .rst_n            (rst_n),
        .start            (start),
        .cfg_rows         (cfg_rows),
        .cfg_cols         (cfg_cols),
        .cfg_kernel       (cfg_kernel),
        .pix_in_data      (pix_in_data),
        .pix_in_valid     (pix_in_valid),
        .pix_in_rdy       (pix_in_rdy),
        .datain           (datain),
        .datain_valid     (datain_valid),
        .seq_datain_tag   (seq_datain_tag),
        .seq_datain_rdy   (seq_datain_rdy),
        .pixel_datain_tag (pixel_datain_tag),
        .pixel_datain_rdy (pixel_datain_rdy),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err)
    );

    // Closed form of the table: group g>=1 has w0.SEQ=g, w1.SEQ=2+2*floor(g/2), w2..w4 offset by g.
    function automatic logic [DW-1:0] exp_word(input int idx);
        int g, w, rm, rst, p, sq;
        g = idx / 5;
        w = idx % 5;
        rm = 0; rst = 0; p = 0; sq = 0;
        case (w)
            0: begin rst = 1; p = (g == 0) ? 1 : (g - 1) % 2; sq = g; end
            1: begin p = (g == 0) ? 0 : 1 - (g - 1) % 2; sq = 2 + 2 * (g / 2); end
            2: sq = 512 + g;
            3: sq = 513 + g;
            default: begin rm = 1; sq = 514 + g; end
        endcase
        sq = sq % 1024;
        return DW'((rm << 12) | (rst << 11) | (p << 10) | sq);
    endfunction

    task automatic run_stream(input string name, input int rows, input int cols, input int k,
                              input bit stall, input bit poke_start);
        logic [PW-1:0] pix_mem[$];
        logic [DW-1:0] exp, prev_data;
        logic          prev_st, prev_pt;
        bit            prev_hold, poked, s_x, p_x;
        int n_words, total, budget;
        int got_seq, got_pix, up_idx, done_cnt, err_cnt, cyc, tail;
        n_words = 5 * (cols - k + 1);
        total   = rows * cols;
        budget  = 20 * (n_words + total) + 100;
        got_seq = 0; got_pix = 0; up_idx = 0; done_cnt = 0; err_cnt = 0; cyc = 0; tail = 0;
        prev_hold = 0; poked = 0; prev_data = '0; prev_st = 0; prev_pt = 0;
        for (int i = 0; i < total; i++) pix_mem.push_back(PW'($urandom));
        @(negedge clk_500MHz);
        cfg_rows = DIM'(rows); cfg_cols = DIM'(cols); cfg_kernel = DIM'(k);
        start = 1'b1;
        while (tail < 4 && cyc < budget) begin
            @(negedge clk_500MHz);
            cyc++;
            start = 1'b0;
            if (poke_start && !poked && got_pix == total / 2) begin
                start = 1'b1;
                cfg_kernel = '0;
                poked = 1;
            end
            seq_datain_rdy   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            pixel_datain_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_in_valid     = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_in_data      = (up_idx < total) ? pix_mem[up_idx] : PW'($urandom);
            #2;
            if (prev_hold) begin
                n_assert++;
                if (datain !== prev_data || seq_datain_tag !== prev_st || pixel_datain_tag !== prev_pt) begin
                    n_fail++;
                    $display("[TB] FAIL %s hold_stable: datain=%h tags=%b%b, expected %h tags=%b%b",
                             name, datain, seq_datain_tag, pixel_datain_tag, prev_data, prev_st, prev_pt);
                end
            end
            n_assert++;
            if ((seq_datain_tag && pixel_datain_tag) || (!datain_valid && (seq_datain_tag || pixel_datain_tag))) begin
                n_fail++;
                $display("[TB] FAIL %s tag_rules: valid=%b seq_tag=%b pixel_tag=%b", name,
                         datain_valid, seq_datain_tag, pixel_datain_tag);
            end
            s_x = datain_valid && seq_datain_tag && seq_datain_rdy;
            p_x = datain_valid && pixel_datain_tag && pixel_datain_rdy;
            if (s_x) begin
                n_assert++;
                exp = exp_word(got_seq);
                if (got_seq >= n_words || got_pix != 0 || datain !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL %s seq_word[%0d]: got %h, expected %h (words expected %0d)",
                             name, got_seq, datain, exp, n_words);
                end
                got_seq++;
            end
            if (p_x) begin
                n_assert++;
                exp = (got_pix < total) ? DW'(pix_mem[got_pix]) : '0;
                if (got_seq != n_words || got_pix >= total || datain !== exp) begin
                    n_fail++;
                    $display("[TB] FAIL %s pixel[%0d]: got %h, expected %h (seq words seen %0d of %0d)",
                             name, got_pix, datain, exp, got_seq, n_words);
                end
                got_pix++;
            end
            if (up_idx >= total) begin
                n_assert++;
                if (pix_in_rdy !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL %s pix_in_rdy_after_last: got %b, expected 0", name, pix_in_rdy);
                end
            end else if (pix_in_valid && pix_in_rdy) begin
                up_idx++;
            end
            if (cfg_err) err_cnt++;
            if (done) begin
                done_cnt++;
                n_assert++;
                if (got_pix != total) begin
                    n_fail++;
                    $display("[TB] FAIL %s done_timing: pixels delivered %0d, expected %0d", name, got_pix, total);
                end
            end
            if (done_cnt > 0) tail++;
            prev_hold = datain_valid && !s_x && !p_x;
            prev_data = datain;
            prev_st   = seq_datain_tag;
            prev_pt   = pixel_datain_tag;
        end
        n_assert++;
        if (cyc >= budget || done_cnt != 1 || got_seq != n_words || got_pix != total || err_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s run_summary: cycles=%0d/%0d done=%0d seq=%0d pix=%0d cfg_err=%0d busy=%b, expected done=1 seq=%0d pix=%0d cfg_err=0 busy=0",
                     name, cyc, budget, done_cnt, got_seq, got_pix, err_cnt, busy, n_words, total);
        end
        seq_datain_rdy = 1'b1; pixel_datain_rdy = 1'b1; pix_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_500MHz);
        #2;
        n_assert++;
        if ({datain, datain_valid, seq_datain_tag, pixel_datain_tag, busy, done, cfg_err, pix_in_rdy} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: datain=%h v=%b st=%b pt=%b busy=%b done=%b err=%b rdy=%b, expected all 0",
                     datain, datain_valid, seq_datain_tag, pixel_datain_tag, busy, done, cfg_err, pix_in_rdy);
        end
        @(negedge clk_500MHz);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_500MHz);
        #2;
        n_assert++;
        if (busy !== 1'b0 || datain_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: busy=%b valid=%b, expected 0 0", busy, datain_valid);
        end
    endtask

    task automatic test_cfg_err(input string name, input int rows, input int cols, input int k);
        @(negedge clk_500MHz);
        cfg_rows = DIM'(rows); cfg_cols = DIM'(cols); cfg_kernel = DIM'(k);
        start = 1'b1;
        @(negedge clk_500MHz);
        start = 1'b0;
        #2;
        n_assert++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || datain_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s cfg_err_pulse: err=%b busy=%b valid=%b, expected 1 0 0", name, cfg_err, busy, datain_valid);
        end
        repeat (4) begin
            @(negedge clk_500MHz);
            #2;
            n_assert++;
            if (cfg_err !== 1'b0 || busy !== 1'b0 || datain_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL %s cfg_err_after: err=%b busy=%b valid=%b, expected 0 0 0", name, cfg_err, busy, datain_valid);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int  got;
        bit  hit;
        logic [DW-1:0] exp;
        got = 0; hit = 0;
        @(negedge clk_500MHz);
        cfg_rows = 10; cfg_cols = 10; cfg_kernel = 3;
        start = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk_500MHz);
            start = 1'b0;
            #2;
            if (datain_valid && seq_datain_tag) begin
                if (got == 20) begin
                    hit = 1;
                    exp = exp_word(20);
                    n_assert++;
                    if (datain !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL word20_before_reset: got %h, expected %h", datain, exp);
                    end
                    #1 rst_n = 1'b0;
                    #1;
                    n_assert++;
                    if ({datain, datain_valid, seq_datain_tag, pixel_datain_tag, busy, done, cfg_err, pix_in_rdy} !== '0) begin
                        n_fail++;
                        $display("[TB] FAIL async_reset_outputs: datain=%h v=%b st=%b pt=%b busy=%b done=%b err=%b, expected all 0",
                                 datain, datain_valid, seq_datain_tag, pixel_datain_tag, busy, done, cfg_err);
                    end
                end else if (seq_datain_rdy) begin
                    got++;
                end
            end
        end
        n_assert++;
        if (!hit) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_run_reach: words seen %0d, expected to reach word 20", got);
        end
        @(negedge clk_500MHz);
        rst_n = 1'b1;
        run_stream("rerun_after_reset", 10, 10, 3, 0, 0);
    endtask

    task automatic test_random_configs();
        int r, c, k;
        for (int n = 0; n < 4; n++) begin
            r = $urandom_range(1, 8);
            c = $urandom_range(1, 8);
            k = $urandom_range(1, (r < c) ? r : c);
            run_stream("random_cfg", r, c, k, 1, 0);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        cfg_rows = '0; cfg_cols = '0; cfg_kernel = '0;
        pix_in_data = '0; pix_in_valid = 1'b0;
        seq_datain_rdy = 1'b1; pixel_datain_rdy = 1'b1;
        #2 rst_n = 1'b0;
        test_reset();
        run_stream("nominal_10x10_k3", 10, 10, 3, 0, 0);
        run_stream("stalled_10x10_k3", 10, 10, 3, 1, 0);
        test_cfg_err("k_zero", 10, 10, 0);
        test_cfg_err("k_over_cols", 10, 10, 11);
        run_stream("single_group_5x5_k5", 5, 5, 5, 0, 0);
        test_reset_mid_run();
        run_stream("start_during_pix", 10, 10, 3, 0, 1);
        test_random_configs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
